// File: rtl/mm_feeder.sv
// mm_feeder: operand skewing sequencer and result collector for an NxN systolic PE array.
// Revision 1.0
`default_nettype none

module mm_feeder #(
  parameter int N         = 4,
  parameter int DATAWIDTH = 8,
  parameter int ACCW      = 2*DATAWIDTH+1,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATAWIDTH-1:0] in_a,
  input  logic [N*DATAWIDTH-1:0] in_b,
  output logic [N*DATAWIDTH-1:0] arr_a,
  output logic [N*DATAWIDTH-1:0] arr_b,
  output logic [1:0]             arr_start,
  output logic                   arr_clr,
  input  logic [N*N*ACCW-1:0]    arr_res,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACCW-1:0]        res_data,
  output logic [IW-1:0]          res_row,
  output logic [IW-1:0]          res_col,
  output logic                   res_last
);

  localparam int RW = (N > 1) ? $clog2(N*N) : 1;
  localparam int CW = $clog2(N*N + 3*N) + 1;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_CAPTURE = 3'd3,
    S_LATCH   = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic                 cnt_inc;
  logic                 clr_hold;
  logic [IW-1:0]        kidx;
  logic [RW-1:0]        ridx;
  logic [RW-1:0]        rrow;
  logic [RW-1:0]        rcol;
  logic [DATAWIDTH-1:0] abuf [N][N];
  logic [DATAWIDTH-1:0] bbuf [N][N];
  logic [ACCW-1:0]      rbuf [N*N];

  // One counter serves as beat index k in LOAD, time step t in FEED and beat r in DRAIN.
  assign kidx = cnt[IW-1:0];
  assign ridx = cnt[RW-1:0];
  assign rrow = ridx / RW'(N);
  assign rcol = ridx % RW'(N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    arr_start = 2'b11;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        cnt_inc  = in_valid;
        if (in_valid && cnt == CW'(N-1)) state_nxt = S_CLEAR;
      end
      S_CLEAR: state_nxt = S_FEED;
      S_FEED: begin
        arr_start = 2'b00;
        cnt_inc   = 1'b1;
        if (cnt == CW'(3*N-3)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        arr_start = 2'b10;
        state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = S_DRAIN;
      S_DRAIN: begin
        res_valid = 1'b1;
        cnt_inc   = res_ready;
        if (res_ready && cnt == CW'(N*N-1)) state_nxt = S_DRAIN == state ? S_LOAD : S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (cnt_inc)            cnt <= cnt + 1'b1;
  end

  // Keeps the array cleared from reset assertion through the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_hold <= 1'b1;
    else     clr_hold <= 1'b0;
  end

  assign arr_clr = clr_hold | (state == S_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          abuf[i][k] <= '0;
          bbuf[i][k] <= '0;
        end
      end
    end else if (state == S_LOAD && in_valid) begin
      for (int i = 0; i < N; i++) begin
        abuf[i][kidx] <= in_a[i*DATAWIDTH +: DATAWIDTH];
        bbuf[kidx][i] <= in_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N*N; r++) rbuf[r] <= '0;
    end else if (state == S_LATCH) begin
      for (int r = 0; r < N*N; r++) rbuf[r] <= arr_res[r*ACCW +: ACCW];
    end
  end

  // Lane i at step t carries the operand with inner index k = t - i; everything else is zero.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (state == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt) == i + k) begin
            arr_a[i*DATAWIDTH +: DATAWIDTH] = abuf[i][k];
            arr_b[i*DATAWIDTH +: DATAWIDTH] = bbuf[k][i];
          end
        end
      end
    end
  end

  assign res_data = (state == S_DRAIN) ? rbuf[ridx] : '0;
  assign res_row  = (state == S_DRAIN) ? rrow[IW-1:0] : '0;
  assign res_col  = (state == S_DRAIN) ? rcol[IW-1:0] : '0;
  assign res_last = (state == S_DRAIN) && (cnt == CW'(N*N-1));

endmodule

`default_nettype wire
